// File: rtl/axi_arbiter_m2s_s3_pkg.sv
// Shared definitions for the master-to-slave AXI request arbiter.
// Holds the write/read FSM state encodings, the default highest-master
// index and the statistics counter width.
package axi_arb_pkg;

    localparam int NUM_DEF = 3;   // highest master index (NUM+1 masters)
    localparam int CNT_W   = 16;  // handshake counter width

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_ADDR = 2'd1,
        WS_DATA = 2'd2
    } wstate_e;

    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_ADDR = 1'b1
    } rstate_e;

endpackage

// File: rtl/axi_arbiter_m2s_s3_if.sv
// Request/grant bundle between the masters' AW/W/AR channels and the arbiter
// of one slave port.
//   master modport : requester/slave-ready side (drives selects, valids,
//                    WLAST and the slave READYs; sees the grants)
//   slave modport  : arbiter side (sees requests, drives AWGRANT/WGRANT/ARGRANT)
interface axi_arbiter_m2s_s3_if
    import axi_arb_pkg::*;
#(
    parameter int NUM = NUM_DEF
);
    logic [NUM:0] AWSELECT;
    logic [NUM:0] AWVALID;
    logic         AWREADY;
    logic [NUM:0] AWGRANT;
    logic [NUM:0] WVALID;
    logic [NUM:0] WLAST;
    logic         WREADY;
    logic [NUM:0] WGRANT;
    logic [NUM:0] ARSELECT;
    logic [NUM:0] ARVALID;
    logic         ARREADY;
    logic [NUM:0] ARGRANT;

    modport master (
        output AWSELECT, AWVALID, AWREADY, WVALID, WLAST, WREADY,
               ARSELECT, ARVALID, ARREADY,
        input  AWGRANT, WGRANT, ARGRANT
    );

    modport slave (
        input  AWSELECT, AWVALID, AWREADY, WVALID, WLAST, WREADY,
               ARSELECT, ARVALID, ARREADY,
        output AWGRANT, WGRANT, ARGRANT
    );
endinterface

// File: rtl/axi_arbiter_m2s_s3_rr.sv
// round_robin_m2s: round-robin pointer plus scan.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-master request vector
//   adv        : move the pointer to the current winner
//   sel        : one-hot winner (zero when no request), combinational
// The pointer resets to NUM so master 0 has top priority after reset.
module round_robin_m2s #(
    parameter int NUM = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [NUM:0] req,
    input  logic         adv,
    output logic [NUM:0] sel
);
    localparam int PW = (NUM > 0) ? $clog2(NUM + 1) : 1;

    logic [PW-1:0] last_q, last_d;
    logic [PW-1:0] widx;
    logic          found;
    int            idx;

    // Scan last+1, last+2, ... wrapping modulo NUM+1; first requester wins.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        widx   = last_q;
        idx    = 0;
        last_d = last_q;
        for (int k = 1; k <= NUM + 1; k++) begin
            if (int'(last_q) + k > NUM) idx = int'(last_q) + k - (NUM + 1);
            else                        idx = int'(last_q) + k;
            if (!found && req[idx]) begin
                found    = 1'b1;
                sel[idx] = 1'b1;
                widx     = PW'(idx);
            end
        end
        if (adv && found) last_d = widx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= PW'(NUM);
        else        last_q <= last_d;
    end
endmodule

// File: rtl/axi_arbiter_m2s_s3.sv
// axi_arbiter_m2s_s3: AW/W/AR request arbiter for one slave port.
//   AXI_CLK, AXI_RSTn : clock, asynchronous active-low reset
//   bus (slave)       : selects/valids/WLAST/READYs in, AW/W/AR grants out
//   AWCNT, ARCNT      : saturating handshake counters, present only when
//                       AXI_ARB_M2S_STAT_EN is defined
// Writes and reads arbitrate independently. A write grant is held from the
// AW grant through the WLAST handshake so W bursts never interleave.
module axi_arbiter_m2s_s3
    import axi_arb_pkg::*;
#(
    parameter int NUM = NUM_DEF
) (
    input  logic             AXI_CLK,
    input  logic             AXI_RSTn,
`ifdef AXI_ARB_M2S_STAT_EN
    output logic [CNT_W-1:0] AWCNT,
    output logic [CNT_W-1:0] ARCNT,
`endif
    axi_arbiter_m2s_s3_if.slave bus
);
    wstate_e      ws_q, ws_d;
    rstate_e      rs_q, rs_d;
    logic [NUM:0] wgnt_q, wgnt_d, rgnt_q, rgnt_d;
    logic         wdone_q, wdone_d;
    logic [NUM:0] aw_req, ar_req, w_rr_req, r_rr_req, w_win, r_win;
    logic [NUM:0] aw_gnt, w_gnt, ar_gnt;
    logic         w_adv, r_adv, aw_hs, wl_hs, ar_hs;

    assign aw_req = bus.AWSELECT & bus.AWVALID;
    assign ar_req = bus.ARSELECT & bus.ARVALID;

    // While a grant is latched the scanner sees only that master, so its
    // winner equals the latched grant and an advance lands the pointer there.
    assign w_rr_req = (ws_q == WS_IDLE) ? aw_req : wgnt_q;
    assign r_rr_req = (rs_q == RS_IDLE) ? ar_req : rgnt_q;

    round_robin_m2s #(.NUM(NUM)) u_rr_w (
        .clk(AXI_CLK), .rst_n(AXI_RSTn), .req(w_rr_req), .adv(w_adv), .sel(w_win)
    );
    round_robin_m2s #(.NUM(NUM)) u_rr_r (
        .clk(AXI_CLK), .rst_n(AXI_RSTn), .req(r_rr_req), .adv(r_adv), .sel(r_win)
    );

    always_comb begin
        ws_d    = ws_q;
        wgnt_d  = wgnt_q;
        wdone_d = wdone_q;
        w_adv   = 1'b0;
        aw_gnt  = '0;
        w_gnt   = '0;
        case (ws_q)
            WS_IDLE: begin aw_gnt = w_win;  w_gnt = w_win;  end
            WS_ADDR: begin aw_gnt = wgnt_q; w_gnt = wgnt_q; end
            WS_DATA: begin                  w_gnt = wgnt_q; end
            default: ;
        endcase
        aw_hs = (|(aw_gnt & bus.AWVALID)) & bus.AWREADY;
        wl_hs = (|(w_gnt & bus.WVALID & bus.WLAST)) & bus.WREADY;
        case (ws_q)
            WS_IDLE: begin
                if (|w_win) begin
                    if (aw_hs && wl_hs) begin
                        w_adv = 1'b1;
                    end else begin
                        wgnt_d = w_win;
                        ws_d   = aw_hs ? WS_DATA : WS_ADDR;
                        // A whole W burst may finish before its AW is accepted.
                        wdone_d = !aw_hs && wl_hs;
                    end
                end
            end
            WS_ADDR: begin
                if (aw_hs) begin
                    if (wdone_q || wl_hs) begin
                        ws_d    = WS_IDLE;
                        w_adv   = 1'b1;
                        wgnt_d  = '0;
                        wdone_d = 1'b0;
                    end else begin
                        ws_d = WS_DATA;
                    end
                end else if (wl_hs) begin
                    wdone_d = 1'b1;
                end
            end
            WS_DATA: begin
                if (wl_hs) begin
                    ws_d    = WS_IDLE;
                    w_adv   = 1'b1;
                    wgnt_d  = '0;
                    wdone_d = 1'b0;
                end
            end
            default: ws_d = WS_IDLE;
        endcase
    end

    always_comb begin
        rs_d   = rs_q;
        rgnt_d = rgnt_q;
        r_adv  = 1'b0;
        ar_gnt = (rs_q == RS_IDLE) ? r_win : rgnt_q;
        ar_hs  = (|(ar_gnt & bus.ARVALID)) & bus.ARREADY;
        case (rs_q)
            RS_IDLE: begin
                if (|r_win) begin
                    if (ar_hs) begin
                        r_adv = 1'b1;
                    end else begin
                        rgnt_d = r_win;
                        rs_d   = RS_ADDR;
                    end
                end
            end
            RS_ADDR: begin
                if (ar_hs) begin
                    rs_d   = RS_IDLE;
                    r_adv  = 1'b1;
                    rgnt_d = '0;
                end
            end
            default: rs_d = RS_IDLE;
        endcase
    end

    always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
        if (!AXI_RSTn) begin
            ws_q    <= WS_IDLE;
            rs_q    <= RS_IDLE;
            wgnt_q  <= '0;
            rgnt_q  <= '0;
            wdone_q <= 1'b0;
        end else begin
            ws_q    <= ws_d;
            rs_q    <= rs_d;
            wgnt_q  <= wgnt_d;
            rgnt_q  <= rgnt_d;
            wdone_q <= wdone_d;
        end
    end

    // Grants are forced low during reset; the IDLE grant path is
    // combinational from the requests and would otherwise be live.
    assign bus.AWGRANT = AXI_RSTn ? aw_gnt : '0;
    assign bus.WGRANT  = AXI_RSTn ? w_gnt  : '0;
    assign bus.ARGRANT = AXI_RSTn ? ar_gnt : '0;

`ifdef AXI_ARB_M2S_STAT_EN
    logic [CNT_W-1:0] awcnt_q, awcnt_d, arcnt_q, arcnt_d;

    always_comb begin
        awcnt_d = awcnt_q;
        arcnt_d = arcnt_q;
        if (aw_hs && (awcnt_q != '1)) awcnt_d = awcnt_q + CNT_W'(1);
        if (ar_hs && (arcnt_q != '1)) arcnt_d = arcnt_q + CNT_W'(1);
    end

    always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
        if (!AXI_RSTn) begin
            awcnt_q <= '0;
            arcnt_q <= '0;
        end else begin
            awcnt_q <= awcnt_d;
            arcnt_q <= arcnt_d;
        end
    end

    assign AWCNT = awcnt_q;
    assign ARCNT = arcnt_q;
`endif
endmodule
